// File: rtl/i2c_slave_fsm_if.sv
// i2c_slave_fsm_if: bus clock, read-data sources and receive/status outputs of the I2C target.
interface i2c_slave_fsm_if #(
  parameter int DATA_LEN = 8
);
  logic                scl;
  logic [DATA_LEN-1:0] tx_data_1;
  logic [DATA_LEN-1:0] tx_data_2;
  logic [DATA_LEN-1:0] rx_data_1;
  logic [DATA_LEN-1:0] rx_data_2;
  logic                rx_valid;
  logic                addr_match;
  logic                rw;
  logic                busy;
  logic [3:0]          state_slave;
  modport master (
    output scl, tx_data_1, tx_data_2,
    input  rx_data_1, rx_data_2, rx_valid, addr_match, rw, busy, state_slave
  );
  modport slave (
    input  scl, tx_data_1, tx_data_2,
    output rx_data_1, rx_data_2, rx_valid, addr_match, rw, busy, state_slave
  );
endinterface

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target that ACKs its address, stores two write bytes and serves two read bytes.
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN   = 7,
  parameter int                  DATA_LEN   = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic           clk,
  input  logic           rst_n,
  inout  wire            sda,
  i2c_slave_fsm_if.slave bus
);
  localparam int BW = $clog2(DATA_LEN);
  localparam logic [BW-1:0] LAST = BW'(DATA_LEN - 1);
  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_GET_ADDR  = 4'h1,
    S_ACK_ADDR  = 4'h2,
    S_RX_BYTE   = 4'h3,
    S_ACK_RX    = 4'h4,
    S_TX_BYTE   = 4'h5,
    S_CHECK_ACK = 4'h6,
    S_WAIT_STOP = 4'h7
  } state_t;
  state_t              state;
  logic [2:0]          scl_s;
  logic [2:0]          sda_s;
  logic                scl_rise;
  logic                scl_fall;
  logic                start;
  logic                stop;
  logic                sda_low;
  logic                full;
  logic                rw;
  logic                busy;
  logic                rx_valid;
  logic                addr_match;
  logic [BW-1:0]       bit_cnt;
  logic [1:0]          byte_cnt;
  logic [DATA_LEN-1:0] shift;
  logic [DATA_LEN-1:0] tx_shift;
  logic [DATA_LEN-1:0] rx_data_1;
  logic [DATA_LEN-1:0] rx_data_2;
  logic [DATA_LEN-1:0] tx_next;
  logic                sda_b;
  assign sda                 = sda_low ? 1'b0 : 1'bz;
  assign sda_b               = sda_s[2];
  assign tx_next             = byte_cnt[0] ? bus.tx_data_2 : bus.tx_data_1;
  assign bus.rx_data_1       = rx_data_1;
  assign bus.rx_data_2       = rx_data_2;
  assign bus.rx_valid        = rx_valid;
  assign bus.addr_match      = addr_match;
  assign bus.rw              = rw;
  assign bus.busy            = busy;
  assign bus.state_slave     = state;
  // Sync flops idle high so reset release never looks like a bus edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_s    <= '1;
      sda_s    <= '1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_s    <= {scl_s[1:0], bus.scl};
      sda_s    <= {sda_s[1:0], sda};
      scl_rise <= scl_s[1] & ~scl_s[2];
      scl_fall <= ~scl_s[1] & scl_s[2];
      start    <= scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
      stop     <= scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
    end
  // full marks a complete byte in Get_Address/Rx_Byte and a seen ACK in Check_ACK.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      sda_low    <= 1'b0;
      full       <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      tx_shift   <= '0;
      rx_data_1  <= '0;
      rx_data_2  <= '0;
    end else begin
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        sda_low  <= 1'b0;
        busy     <= 1'b0;
        full     <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (start) begin
        state    <= S_GET_ADDR;
        sda_low  <= 1'b0;
        busy     <= 1'b1;
        full     <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (scl_rise) begin
        if (state == S_GET_ADDR || state == S_RX_BYTE) begin
          shift   <= {shift[DATA_LEN-2:0], sda_b};
          bit_cnt <= bit_cnt + 1'b1;
          full    <= bit_cnt == LAST;
        end else if (state == S_CHECK_ACK) begin
          if (sda_b) state <= S_WAIT_STOP;
          else full <= 1'b1;
        end
      end else if (scl_fall) begin
        case (state)
          S_GET_ADDR:
            if (full) begin
              full <= 1'b0;
              if (shift[ADDR_LEN:1] == SLAVE_ADDR) begin
                state      <= S_ACK_ADDR;
                sda_low    <= 1'b1;
                addr_match <= 1'b1;
                rw         <= shift[0];
              end else begin
                state   <= S_WAIT_STOP;
                sda_low <= 1'b0;
              end
            end
          S_ACK_ADDR:
            if (rw) begin
              state    <= S_TX_BYTE;
              sda_low  <= ~tx_next[DATA_LEN-1];
              tx_shift <= tx_next << 1;
              bit_cnt  <= BW'(1);
              byte_cnt <= {1'b0, ~byte_cnt[0]};
            end else begin
              state   <= S_RX_BYTE;
              sda_low <= 1'b0;
              bit_cnt <= '0;
              full    <= 1'b0;
            end
          S_RX_BYTE:
            if (full) begin
              state <= S_ACK_RX;
              full  <= 1'b0;
              if (byte_cnt != 2'd2) begin
                sda_low  <= 1'b1;
                rx_valid <= 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 2'd0) rx_data_1 <= shift;
                else rx_data_2 <= shift;
              end else begin
                sda_low <= 1'b0;
              end
            end
          S_ACK_RX: begin
            state   <= S_RX_BYTE;
            sda_low <= 1'b0;
            bit_cnt <= '0;
          end
          S_TX_BYTE:
            if (bit_cnt == '0) begin
              state   <= S_CHECK_ACK;
              sda_low <= 1'b0;
              full    <= 1'b0;
            end else begin
              sda_low  <= ~tx_shift[DATA_LEN-1];
              tx_shift <= tx_shift << 1;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          S_CHECK_ACK:
            if (full) begin
              state    <= S_TX_BYTE;
              full     <= 1'b0;
              sda_low  <= ~tx_next[DATA_LEN-1];
              tx_shift <= tx_next << 1;
              bit_cnt  <= BW'(1);
              byte_cnt <= {1'b0, ~byte_cnt[0]};
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: bit-banged I2C master with a transaction-level model of what the target must do.
module tb_i2c_slave_fsm;
  localparam logic [6:0] OWN = 7'h50;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_low = 1'b0;
  wire        sda;
  int         checks = 0;
  int         errors = 0;
  int         cnt_valid = 0;
  int         cnt_match = 0;
  int         exp_valid = 0;
  int         exp_match = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [7:0] md[2];
  logic [7:0] p1 = '0;
  logic [7:0] p2 = '0;
  logic       pv = 1'b0;
  logic       pm = 1'b0;
  logic       rst_q = 1'b0;
  i2c_slave_fsm_if bus ();
  i2c_slave_fsm dut (.clk(clk), .rst_n(rst_n), .sda(sda), .bus(bus));
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Every stored byte must match the model's queue and every pulse must sit on an ACK drive.
  always @(negedge clk) begin
    if (rst_n && rst_q) begin
      if (bus.rx_valid) begin
        cnt_valid++;
        chk("valid_width", 32'(pv), 0);
        chk("valid_ack_drive", 32'(sda), 0);
        chk("store_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(e[9:8] == 2'd1 ? "rx_data_1" : "rx_data_2",
              e[9:8] == 2'd1 ? 32'(bus.rx_data_1) : 32'(bus.rx_data_2), 32'(e[7:0]));
        end
      end else begin
        chk("rx_hold", {bus.rx_data_1, bus.rx_data_2}, {p1, p2});
      end
      if (bus.addr_match) begin
        cnt_match++;
        chk("match_width", 32'(pm), 0);
        chk("match_ack_drive", 32'(sda), 0);
      end
    end
    p1    = bus.rx_data_1;
    p2    = bus.rx_data_2;
    pv    = bus.rx_valid;
    pm    = bus.addr_match;
    rst_q = rst_n;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clock_bit(input logic b, output logic r);
    m_low = ~b;
    tick(6);
    r = sda;
    bus.scl = 1'b1;
    tick(4);
    bus.scl = 1'b0;
    tick(2);
  endtask
  task automatic send_start();
    if (!bus.scl) begin
      m_low = 1'b0;
      tick(3);
      bus.scl = 1'b1;
      tick(5);
    end
    m_low = 1'b1;
    tick(5);
    bus.scl = 1'b0;
    tick(2);
  endtask
  task automatic send_stop();
    m_low = 1'b1;
    tick(3);
    bus.scl = 1'b1;
    tick(5);
    m_low = 1'b0;
    tick(6);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], r);
      chk("bus_bit", 32'(r), 32'(b[i]));
    end
    clock_bit(1'b1, ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      v = {v[6:0], r};
    end
    clock_bit(nack, r);
  endtask
  // Model: only our address ACKs, only the first two write bytes are ACKed and stored.
  task automatic xfer_write(input logic [6:0] a, input int n, input logic [7:0] d0, d1, d2);
    logic [7:0] d[3];
    logic       ack;
    bit         m;
    d = '{d0, d1, d2};
    m = (a == OWN);
    send_start();
    chk("start_busy", 32'(bus.busy), 1);
    send_byte({a, 1'b0}, ack);
    chk("addr_ack", 32'(ack), m ? 0 : 1);
    if (m) exp_match++;
    for (int i = 0; i < n; i++) begin
      if (m && i < 2) begin
        exp_q.push_back({2'(i + 1), d[i]});
        exp_valid++;
      end
      send_byte(d[i], ack);
      chk("data_ack", 32'(ack), (m && i < 2) ? 0 : 1);
    end
  endtask
  initial begin
    logic       ack;
    logic [7:0] v;
    bus.scl = 1'b1;
    md = '{8'h00, 8'h00};
    bus.tx_data_1 = md[0];
    bus.tx_data_2 = md[1];
    tick(3);
    chk("rst_state", 32'(bus.state_slave), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rw", 32'(bus.rw), 0);
    chk("rst_rx", {bus.rx_data_1, bus.rx_data_2}, 0);
    chk("rst_sda", 32'(sda), 1);
    rst_n = 1'b1;
    tick(5);
    xfer_write(OWN, 2, 8'hA5, 8'h3C, 8'h00);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_rw", 32'(bus.rw), 0);
    send_stop();
    chk("t1_state", 32'(bus.state_slave), 0);
    chk("t1_busy_off", 32'(bus.busy), 0);
    chk("t1_rx1", 32'(bus.rx_data_1), 32'h A5);
    chk("t1_rx2", 32'(bus.rx_data_2), 32'h3C);
    chk("t1_valid_cnt", cnt_valid, 2);
    chk("t1_match_cnt", cnt_match, 1);
    xfer_write(7'h51, 1, 8'hFF, 8'h00, 8'h00);
    tick(4);
    chk("t2_wait_stop", 32'(bus.state_slave), 4'h7);
    chk("t2_match_cnt", cnt_match, exp_match);
    send_stop();
    chk("t2_idle", 32'(bus.state_slave), 0);
    md = '{8'h96, 8'h0F};
    bus.tx_data_1 = md[0];
    bus.tx_data_2 = md[1];
    send_start();
    send_byte({OWN, 1'b1}, ack);
    chk("t3_addr_ack", 32'(ack), 0);
    exp_match++;
    recv_byte(1'b0, v);
    chk("t3_byte1", 32'(v), 32'(md[0]));
    chk("t3_byte1_lit", 32'(v), 32'h96);
    recv_byte(1'b1, v);
    chk("t3_byte2", 32'(v), 32'(md[1]));
    chk("t3_byte2_lit", 32'(v), 32'h0F);
    tick(4);
    chk("t3_released", 32'(sda), 1);
    chk("t3_wait_stop", 32'(bus.state_slave), 4'h7);
    chk("t3_rw", 32'(bus.rw), 1);
    send_stop();
    chk("t3_idle", 32'(bus.state_slave), 0);
    chk("t3_busy_off", 32'(bus.busy), 0);
    xfer_write(OWN, 3, 8'h11, 8'h22, 8'h33);
    send_stop();
    chk("t4_rx1", 32'(bus.rx_data_1), 32'h11);
    chk("t4_rx2", 32'(bus.rx_data_2), 32'h22);
    chk("t4_valid_cnt", cnt_valid, exp_valid);
    md = '{8'hC3, 8'h5A};
    bus.tx_data_1 = md[0];
    bus.tx_data_2 = md[1];
    send_start();
    send_byte({OWN, 1'b0}, ack);
    chk("t5_waddr_ack", 32'(ack), 0);
    exp_match++;
    send_start();
    chk("t5_rs_state", 32'(bus.state_slave), 4'h1);
    chk("t5_rs_busy", 32'(bus.busy), 1);
    send_byte({OWN, 1'b1}, ack);
    chk("t5_raddr_ack", 32'(ack), 0);
    exp_match++;
    chk("t5_rw", 32'(bus.rw), 1);
    recv_byte(1'b1, v);
    chk("t5_first_byte", 32'(v), 32'(md[0]));
    tick(4);
    chk("t5_wait_stop", 32'(bus.state_slave), 4'h7);
    send_stop();
    md = '{8'h00, 8'h00};
    bus.tx_data_1 = md[0];
    bus.tx_data_2 = md[1];
    send_start();
    send_byte({OWN, 1'b1}, ack);
    chk("t6_addr_ack", 32'(ack), 0);
    exp_match++;
    clock_bit(1'b1, ack);
    chk("t6_bit7", 32'(ack), 0);
    clock_bit(1'b1, ack);
    chk("t6_bit6", 32'(ack), 0);
    tick(3);
    chk("t6_driving", 32'(sda), 0);
    chk("t6_tx_state", 32'(bus.state_slave), 4'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_sda", 32'(sda), 1);
    chk("t6_rst_state", 32'(bus.state_slave), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_rw", 32'(bus.rw), 0);
    chk("t6_rst_rx", {bus.rx_data_1, bus.rx_data_2}, 0);
    chk("t6_rst_pulses", {bus.rx_valid, bus.addr_match}, 0);
    tick(2);
    bus.scl = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(5);
    xfer_write(OWN, 1, 8'h5A, 8'h00, 8'h00);
    send_stop();
    chk("t6_rx1", 32'(bus.rx_data_1), 32'h5A);
    chk("t6_rx2", 32'(bus.rx_data_2), 0);
    chk("t6_idle", 32'(bus.state_slave), 0);
    chk("final_valid_cnt", cnt_valid, exp_valid);
    chk("final_match_cnt", cnt_match, exp_match);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
